// File: rtl/waveform_fetch.sv
// Logic-analyser waveform renderer: fetches capture samples for the current VGA pixel
// and draws one channel band per data bit, with a two-clock pixel pipeline.
module waveform_fetch #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BAND       = 60,
  parameter int HI_ROW     = 10,
  parameter int LO_ROW     = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  video_on,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  capture_done,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [1:0]            zoom,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  pixel_on,
  output logic [9:0]            pix_x_d,
  output logic [9:0]            pix_y_d
);

  localparam int BR_W = (BAND > 1) ? $clog2(BAND) : 1;
  localparam int CH_W = $clog2(V_ACTIVE / BAND + 2);
  localparam logic [BR_W-1:0] BAND_LAST = BR_W'(BAND - 1);
  localparam logic [BR_W-1:0] HI_R      = BR_W'(HI_ROW);
  localparam logic [BR_W-1:0] LO_R      = BR_W'(LO_ROW);
  localparam logic [9:0]      X_LAST    = 10'(H_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, SHOW} state_t;

  state_t state_q, state_d;

  logic                  frame_start, line_end;
  logic                  latch_en, addr_en, disp_en;
  logic [ADDR_WIDTH-1:0] base_q, eff_base;
  logic [1:0]            zoom_q, eff_zoom;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [BR_W-1:0]       band_q, band_cur, band_d;
  logic [CH_W-1:0]       chan_q, chan_cur, chan_d;
  logic [9:0]            x1_q, y1_q;
  logic                  von1_q;
  logic [BR_W-1:0]       band1_q;
  logic [CH_W-1:0]       chan1_q;
  logic                  prev_bit_q, prev_eff, cur_bit;
  logic [DATA_WIDTH-1:0] sel_mask;
  logic                  pixel_on_q, pixel_on_d;
  logic [9:0]            pix_x_q, pix_y_q;

  assign frame_start = video_on && (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign line_end    = video_on && (pixel_x == X_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (capture_done) state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        if (!capture_done)    state_d = IDLE;
        else if (frame_start) state_d = SHOW;
      end
      SHOW:       if (frame_start) state_d = capture_done ? SHOW : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // FSM outputs: base/zoom only move at a frame start; the address path follows the
  // state being entered so the frame-start pixel already uses the new base.
  always_comb begin
    latch_en = 1'b0;
    addr_en  = 1'b0;
    disp_en  = 1'b0;
    latch_en = frame_start && capture_done && (state_q == WAIT_FRAME || state_q == SHOW);
    addr_en  = (state_d == SHOW);
    disp_en  = (state_q == SHOW);
  end

  always_comb begin
    eff_base  = latch_en ? start_addr : base_q;
    eff_zoom  = latch_en ? zoom : zoom_q;
    rd_addr_d = addr_en ? (eff_base + ADDR_WIDTH'(pixel_x >> eff_zoom)) : '0;
  end

  // Band counters describe the current line; the frame-start pixel sees them already cleared.
  always_comb begin
    band_cur = frame_start ? '0 : band_q;
    chan_cur = frame_start ? '0 : chan_q;
    band_d   = band_cur;
    chan_d   = chan_cur;
    if (line_end) begin
      if (band_cur == BAND_LAST) begin
        band_d = '0;
        chan_d = chan_cur + CH_W'(1);
      end else begin
        band_d = band_cur + BR_W'(1);
      end
    end
  end

  // rd_data here belongs to the pixel held in stage 1; channels past the data width
  // select nothing and read as 0.
  always_comb begin
    sel_mask   = DATA_WIDTH'(1) << chan1_q;
    cur_bit    = |(rd_data & sel_mask);
    prev_eff   = (x1_q == 10'd0) ? cur_bit : prev_bit_q;
    pixel_on_d = disp_en && von1_q && (int'(chan1_q) < DATA_WIDTH) &&
                 ((cur_bit && band1_q == HI_R) ||
                  (!cur_bit && band1_q == LO_R) ||
                  (cur_bit != prev_eff && band1_q >= HI_R && band1_q <= LO_R));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      zoom_q     <= '0;
      rd_addr_q  <= '0;
      band_q     <= '0;
      chan_q     <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      von1_q     <= 1'b0;
      band1_q    <= '0;
      chan1_q    <= '0;
      prev_bit_q <= 1'b0;
      pixel_on_q <= 1'b0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
    end else begin
      if (latch_en) begin
        base_q <= start_addr;
        zoom_q <= zoom;
      end
      rd_addr_q  <= rd_addr_d;
      band_q     <= band_d;
      chan_q     <= chan_d;
      x1_q       <= pixel_x;
      y1_q       <= pixel_y;
      von1_q     <= video_on;
      band1_q    <= band_cur;
      chan1_q    <= chan_cur;
      prev_bit_q <= cur_bit;
      pixel_on_q <= pixel_on_d;
      pix_x_q    <= x1_q;
      pix_y_q    <= y1_q;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign pixel_on = pixel_on_q;
  assign pix_x_d  = pix_x_q;
  assign pix_y_d  = pix_y_q;

endmodule

// File: tb/tb_waveform_fetch.sv
// Scoreboard bench for waveform_fetch: directed compressed rasters push expected
// read addresses and pixels; a negedge monitor pops and compares them.
module tb_waveform_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        video_on;
  logic [9:0]  pixel_x, pixel_y;
  logic        capture_done;
  logic [10:0] start_addr;
  logic [1:0]  zoom;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data;
  logic        pixel_on;
  logic [9:0]  pix_x_d, pix_y_d;

  logic [7:0]  ram [2048];

  typedef struct {
    int addr;
    bit on;
    int x;
    int y;
  } exp_t;

  exp_t qa[$];
  exp_t qp[$];
  exp_t ea, ep;

  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   prev_m = 1'b0;
  logic cd_in = 1'b0;
  int   sa_in = 0;
  int   zm_in = 0;

  waveform_fetch #(
    .ADDR_WIDTH(11),
    .DATA_WIDTH(8),
    .H_ACTIVE(640),
    .V_ACTIVE(480),
    .BAND(60),
    .HI_ROW(10),
    .LO_ROW(50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .video_on(video_on),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .capture_done(capture_done),
    .start_addr(start_addr),
    .zoom(zoom),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .pixel_on(pixel_on),
    .pix_x_d(pix_x_d),
    .pix_y_d(pix_y_d)
  );

  always #5 clk = ~clk;

  // Read data follows the registered address within the next cycle.
  assign rd_data = ram[rd_addr];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (qa.size() > 1) begin
        ea = qa.pop_front();
        chk($sformatf("rd_addr x=%0d y=%0d", ea.x, ea.y), int'(rd_addr), ea.addr);
      end
      if (qp.size() > 2) begin
        ep = qp.pop_front();
        chk($sformatf("pixel_on x=%0d y=%0d", ep.x, ep.y), int'(pixel_on), int'(ep.on));
        chk($sformatf("pix_x_d x=%0d y=%0d", ep.x, ep.y), int'(pix_x_d), ep.x);
        chk($sformatf("pix_y_d x=%0d y=%0d", ep.x, ep.y), int'(pix_y_d), ep.y);
      end
    end
  end

  // Drive one pixel and queue its expected address and foreground bit.
  task automatic drive(input bit von, input int x, input int y, input bit show,
                       input int base, input int zm);
    exp_t e;
    int   a, ch, row;
    bit   b, pr;
    video_on     = von;
    pixel_x      = 10'(x);
    pixel_y      = 10'(y);
    capture_done = cd_in;
    start_addr   = 11'(sa_in);
    zoom         = 2'(zm_in);
    a   = show ? ((base + (x >> zm)) % 2048) : 0;
    ch  = y / 60;
    row = y % 60;
    b   = (ch < 8) ? ram[a][ch] : 1'b0;
    pr  = (x == 0) ? b : prev_m;
    prev_m = b;
    e.addr = a;
    e.x    = x;
    e.y    = y;
    e.on   = show && von && (ch < 8) &&
             ((b && row == 10) || (!b && row == 50) ||
              (b != pr && row >= 10 && row <= 50));
    if (mon_en) begin
      qa.push_back(e);
      qp.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    qa.delete();
    qp.delete();
    rst_n = 1'b0;
    #1;
    chk("midline_rst pixel_on", int'(pixel_on), 0);
    chk("midline_rst rd_addr", int'(rd_addr), 0);
    chk("midline_rst pix_x_d", int'(pix_x_d), 0);
    chk("midline_rst pix_y_d", int'(pix_y_d), 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Compressed raster: x=0..11, then the line-end pixel, then one blank pixel.
  task automatic frame(input bit show, input int base, input int zm, input int nlines,
                       input int chg_line, input int chg_sa, input int chg_zm,
                       input int drop_line, input int rst_line);
    bit sh;
    sh = show;
    for (int y = 0; y < nlines; y++) begin
      if (y == chg_line) begin
        sa_in = chg_sa;
        zm_in = chg_zm;
      end
      if (y == drop_line) cd_in = 1'b0;
      for (int x = 0; x < 12; x++) begin
        if (y == rst_line && x == 5) begin
          do_reset();
          sh = 1'b0;
        end
        drive(1'b1, x, y, sh, base, zm);
      end
      drive(1'b1, 639, y, sh, base, zm);
      drive(1'b0, 640, y, sh, base, zm);
    end
    drive(1'b0, 0, 480, sh, base, zm);
    drive(1'b0, 0, 480, sh, base, zm);
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) ram[k] = (k < 5) ? 8'h01 : 8'h00;
    rst_n        = 1'b0;
    video_on     = 1'b0;
    pixel_x      = '0;
    pixel_y      = '0;
    capture_done = 1'b0;
    start_addr   = '0;
    zoom         = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pixel_on", int'(pixel_on), 0);
    chk("reset rd_addr", int'(rd_addr), 0);
    chk("reset pix_x_d", int'(pix_x_d), 0);
    chk("reset pix_y_d", int'(pix_y_d), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // No capture yet: nothing is drawn.
    frame(1'b0, 0, 0, 3, -1, 0, 0, -1, -1);

    // Arm, then full band 0/1 coverage with base 0; start_addr changes mid-frame.
    cd_in = 1'b1; sa_in = 0; zm_in = 0;
    drive(1'b0, 0, 480, 1'b0, 0, 0);
    drive(1'b0, 0, 480, 1'b0, 0, 0);
    frame(1'b1, 0, 0, 130, 1, 100, 0, -1, -1);
    // base 100, then base 2040 (address wrap), then zoom 2 with capture dropping mid-frame.
    frame(1'b1, 100, 0, 3, 1, 2040, 0, -1, -1);
    frame(1'b1, 2040, 0, 2, 1, 0, 2, -1, -1);
    frame(1'b1, 0, 2, 12, -1, 0, 0, 5, -1);
    frame(1'b0, 0, 0, 12, -1, 0, 0, -1, -1);

    // Re-arm, reset in the middle of a lit row, then display returns on the next frame.
    cd_in = 1'b1; sa_in = 0; zm_in = 0;
    drive(1'b0, 0, 480, 1'b0, 0, 0);
    drive(1'b0, 0, 480, 1'b0, 0, 0);
    frame(1'b1, 0, 0, 12, -1, 0, 0, -1, 10);
    frame(1'b1, 0, 0, 12, -1, 0, 0, -1, -1);
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 480, 1'b1, 0, 0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
